// File: rtl/fetch_control_pkg.sv
// Shared fetch-unit definitions: FSM state codes, PC step default, word/decode payloads.
package fetch_control_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned PC_STEP_DEF = 4;
   localparam int unsigned ST_W        = 3;

   typedef logic [ST_W-1:0] fetch_state_t;

   // Fetch FSM states
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_REQ  = 3'd1;
   localparam logic [2:0] ST_WAIT = 3'd2;
   localparam logic [2:0] ST_HOLD = 3'd3;
   localparam logic [2:0] ST_DROP = 3'd4;

   // Fetched instruction together with the PC it was fetched from
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_word_t;

   // Decode register payload
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } decode_reg_t;

   // Build decode contents from a fetched word; PC arithmetic wraps modulo 2^32
   function automatic decode_reg_t to_decode(input fetch_word_t w);
      decode_reg_t d;
      d.instr    = w.instr;
      d.pc       = w.pc;
      d.pc_plus4 = w.pc + 32'd4;
      return d;
   endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Instruction-memory request/response bundle.
//   master: fetch side (drives imem_req/imem_addr, receives ready/rvalid/rdata)
//   slave : memory side
interface fetch_control_if;
   import fetch_control_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word while decode is stalled.
//   clk/rst : clock, async active-low reset
//   load    : capture din (takes precedence over unload)
//   unload  : entry consumed, buffer empties
//   clear   : flush (redirect), highest priority
//   valid/dout : entry present / entry contents
module fetch_skid_buf
   import fetch_control_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        unload,
   input  logic        clear,
   input  fetch_word_t din,
   output logic        valid,
   output fetch_word_t dout
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_control.sv
// Instruction fetch control: issues one request at a time to instruction memory,
// loads returned words into the decode register, parks one word in a skid buffer
// when decode stalls, and flushes on execute-stage redirects.
//   clk, rst               : clock, async active-low reset
//   redirect_e/pc_target_e : taken branch/jump and its target
//   stall_d                : decode holds its register
//   imem                   : instruction memory bundle (master side)
//   instr_d/pc_d/pc_plus4_d/valid_d : decode register
module fetch_control
   import fetch_control_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = PC_STEP_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect_e,
   input  logic [31:0]            pc_target_e,
   input  logic                   stall_d,
   fetch_control_if.master        imem,
   output logic [31:0]            instr_d,
   output logic [31:0]            pc_d,
   output logic [31:0]            pc_plus4_d,
   output logic                   valid_d
);

   fetch_state_t state_q, state_nx;
   logic [31:0]  pc_q, pc_nx;
   logic         req_q;
   decode_reg_t  dec_q, dec_nx;
   logic         valid_q, valid_nx;
   logic         accept_c;
   logic         skid_load, skid_unload, skid_clear, skid_valid;
   fetch_word_t  rsp_word, skid_word;

   assign accept_c = (state_q == ST_REQ) && imem.imem_ready;
   assign rsp_word = '{instr: imem.imem_rdata, pc: pc_q};

   fetch_skid_buf u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (skid_load),
      .unload (skid_unload),
      .clear  (skid_clear),
      .din    (rsp_word),
      .valid  (skid_valid),
      .dout   (skid_word)
   );

   // Next-state, next-PC and decode-register update
   always_comb begin
      state_nx    = state_q;
      pc_nx       = pc_q;
      dec_nx      = dec_q;
      valid_nx    = valid_q;
      skid_load   = 1'b0;
      skid_unload = 1'b0;
      skid_clear  = 1'b0;

      if (redirect_e) begin
         valid_nx   = 1'b0;
         skid_clear = 1'b0 | 1'b1;
         pc_nx      = pc_target_e;
         // A request still in flight after this edge must have its response dropped
         if ((((state_q == ST_WAIT) || (state_q == ST_DROP)) && !imem.imem_rvalid) || accept_c)
            state_nx = ST_DROP;
         else
            state_nx = ST_REQ;
      end else begin
         // Bubble unless a word loads below
         if (!stall_d)
            valid_nx = 1'b0;

         case (state_q)
            ST_IDLE: state_nx = ST_REQ;
            ST_REQ: begin
               if (accept_c)
                  state_nx = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem.imem_rvalid) begin
                  pc_nx = pc_q + 32'(PC_STEP);
                  if (valid_q && stall_d) begin
                     skid_load = 1'b1;
                     state_nx  = ST_HOLD;
                  end else begin
                     dec_nx   = to_decode(rsp_word);
                     valid_nx = 1'b1;
                     state_nx = ST_REQ;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_d && skid_valid) begin
                  dec_nx      = to_decode(skid_word);
                  valid_nx    = 1'b1;
                  skid_unload = 1'b1;
                  state_nx    = ST_REQ;
               end
            end
            ST_DROP: begin
               if (imem.imem_rvalid)
                  state_nx = ST_REQ;
            end
            default: state_nx = ST_IDLE;
         endcase
      end
   end

   // State, PC and decode register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         req_q   <= 1'b0;
         dec_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_nx;
         pc_q    <= pc_nx;
         req_q   <= (state_nx == ST_REQ);
         dec_q   <= dec_nx;
         valid_q <= valid_nx;
      end
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign instr_d        = dec_q.instr;
   assign pc_d           = dec_q.pc;
   assign pc_plus4_d     = dec_q.pc_plus4;
   assign valid_d        = valid_q;

endmodule

// File: tb/tb_fetch_control.sv
// Randomised bench for fetch_control against a transaction-level fetch model.
module tb_fetch_control;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        redirect_e = 1'b0;
   logic        stall_d = 1'b0;
   logic [31:0] pc_target_e = '0;
   logic [31:0] instr_d, pc_d, pc_plus4_d;
   logic        valid_d;

   fetch_control_if imem ();

   fetch_control #(.RESET_PC(RESET_PC), .PC_STEP(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect_e  (redirect_e),
      .pc_target_e (pc_target_e),
      .stall_d     (stall_d),
      .imem        (imem.master),
      .instr_d     (instr_d),
      .pc_d        (pc_d),
      .pc_plus4_d  (pc_plus4_d),
      .valid_d     (valid_d)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: fetch PC, in-flight request, parked word, decode contents
   bit          m_idle, m_out, m_disc, m_skid_v, m_valid;
   logic [31:0] m_pc, m_skid_i, m_skid_pc, m_instr, m_dpc, m_dp4;

   // Memory responder
   bit          mem_pend;
   int          mem_cnt;
   logic [31:0] mem_word;
   bit          force_word_en;
   logic [31:0] force_word;

   function automatic bit m_req();
      return !m_idle && !m_out && !m_skid_v;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("imem_req",   32'(imem.imem_req), 32'(m_req()));
      check("imem_addr",  imem.imem_addr, m_pc);
      check("valid_d",    32'(valid_d), 32'(m_valid));
      check("instr_d",    instr_d, m_instr);
      check("pc_d",       pc_d, m_dpc);
      check("pc_plus4_d", pc_plus4_d, m_dp4);
   endtask

   task automatic model_reset();
      m_idle = 1; m_out = 0; m_disc = 0; m_skid_v = 0; m_valid = 0;
      m_pc = RESET_PC; m_instr = '0; m_dpc = '0; m_dp4 = '0;
      m_skid_i = '0; m_skid_pc = '0;
   endtask

   // One clock: choose inputs, advance model, clock DUT, compare
   task automatic step(input int p_stall, input int p_redir, input int p_ready,
                       input int max_lat, input bit force_redir, input logic [31:0] force_tgt);
      bit rv, rdy, st, rd, acc, resp, loaded;
      logic [31:0] tgt, rdata;
      rv = 0;
      rdata = $urandom;
      if (mem_pend && mem_cnt == 0) begin
         rv = 1; rdata = mem_word; mem_pend = 0;
      end else if (mem_pend) begin
         mem_cnt--;
      end else if ($urandom_range(99) < 10) begin
         rv = 1;  // stray response with nothing outstanding
      end
      rdy = $urandom_range(99) < p_ready;
      st  = $urandom_range(99) < p_stall;
      rd  = force_redir || ($urandom_range(99) < p_redir);
      if (force_redir) tgt = force_tgt;
      else if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (32'($urandom_range(3)) << 2);
      else tgt = $urandom & 32'hFFFF_FFFC;

      imem.imem_rvalid = rv;
      imem.imem_rdata  = rdata;
      imem.imem_ready  = rdy;
      stall_d          = st;
      redirect_e       = rd;
      pc_target_e      = tgt;

      if (imem.imem_req && rdy) begin
         mem_pend = 1;
         mem_cnt  = $urandom_range(max_lat);
         mem_word = force_word_en ? force_word : $urandom;
      end

      acc  = m_req() && rdy;
      resp = m_out && rv;
      if (rd) begin
         m_valid = 0; m_skid_v = 0; m_pc = tgt;
         m_out = (m_out && !rv) || acc;
         m_disc = m_out;
         m_idle = 0;
      end else begin
         loaded = 0;
         if (resp && !m_disc) begin
            if (m_valid && st) begin
               m_skid_v = 1; m_skid_i = rdata; m_skid_pc = m_pc;
            end else begin
               m_instr = rdata; m_dpc = m_pc; m_dp4 = m_pc + 32'd4;
               m_valid = 1; loaded = 1;
            end
            m_pc = m_pc + 32'd4;
         end else if (m_skid_v && !st) begin
            m_instr = m_skid_i; m_dpc = m_skid_pc; m_dp4 = m_skid_pc + 32'd4;
            m_valid = 1; m_skid_v = 0; loaded = 1;
         end
         if (!loaded && !st) m_valid = 0;
         if (resp) begin m_out = 0; m_disc = 0; end
         if (acc)  begin m_out = 1; m_disc = 0; end
         m_idle = 0;
      end

      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      bit found;
      imem.imem_ready  = 0;
      imem.imem_rvalid = 0;
      imem.imem_rdata  = '0;
      mem_pend = 0; mem_cnt = 0; mem_word = '0;
      force_word_en = 0; force_word = '0;
      model_reset();

      // Reset state
      #12;
      check_all();
      rst = 1;

      // Back-to-back fetches, 1-cycle response: 0,4,8,...
      repeat (12) step(0, 0, 100, 0, 0, '0);

      // Decode stalled: second word parks in skid, released next edge
      force_word_en = 1;
      force_word    = 32'h0050_0093;
      repeat (8) step(100, 0, 100, 0, 0, '0);
      step(0, 0, 100, 0, 0, '0);
      check("skid_release_instr", instr_d, 32'h0050_0093);
      force_word_en = 0;
      repeat (4) step(0, 0, 100, 0, 0, '0);

      // Redirect while waiting (response not yet back): flush and drop
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_out && mem_pend && mem_cnt > 0) found = 1;
         else step(0, 0, 100, 2, 0, '0);
      end
      check("find_wait_slot", 32'(found), 32'd1);
      step(0, 0, 100, 2, 1, 32'h0000_0100);
      check("redir_wait_valid", 32'(valid_d), 32'd0);
      repeat (8) step(0, 0, 100, 2, 0, '0);

      // Redirect coincident with the response: word dropped, request at target
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         if (m_out && mem_pend && mem_cnt == 0) found = 1;
         else step(0, 0, 100, 2, 0, '0);
      end
      check("find_rsp_slot", 32'(found), 32'd1);
      step(0, 0, 100, 2, 1, 32'h0000_0200);
      check("redir_rsp_req", 32'(imem.imem_req), 32'd1);
      check("redir_rsp_addr", imem.imem_addr, 32'h0000_0200);
      repeat (6) step(0, 0, 100, 0, 0, '0);

      // Fetch at the top of the address space wraps to 0
      step(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
      repeat (6) step(0, 0, 100, 0, 0, '0);

      // Random traffic
      repeat (1500) step(30, 5, 70, 3, 0, '0);

      // Reset while a request is outstanding; stale response arrives after release
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         if (m_out && mem_pend && mem_cnt > 0) found = 1;
         else step(10, 0, 100, 3, 0, '0);
      end
      check("find_reset_slot", 32'(found), 32'd1);
      rst = 0;
      imem.imem_rvalid = 0;
      redirect_e = 0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      check_all();
      rst = 1;
      mem_cnt = 0;
      step(0, 0, 100, 0, 0, '0);
      repeat (10) step(0, 0, 100, 0, 0, '0);

      // More random traffic
      repeat (1500) step(40, 8, 60, 3, 0, '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
